// File: rtl/fpu_ss_result_fifo.sv
// Result buffer between the fpu_ss and the core's X-interface result channel.
// Entries can be killed by id after push; killed heads are dropped silently.
module fpu_ss_result_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned XLEN     = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,

  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [ID_WIDTH-1:0]          in_id_i,
  input  logic [4:0]                   in_rd_i,
  input  logic                         in_we_i,
  input  logic [XLEN-1:0]              in_data_i,

  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [ID_WIDTH-1:0]          out_id_o,
  output logic [4:0]                   out_rd_o,
  output logic                         out_we_o,
  output logic [XLEN-1:0]              out_data_o,

  input  logic                         kill_valid_i,
  input  logic [ID_WIDTH-1:0]          kill_id_i,
  input  logic                         flush_i,

  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]    killed_q, killed_d;

  logic [ID_WIDTH-1:0] id_q   [DEPTH];
  logic [4:0]          rd_q   [DEPTH];
  logic                we_q   [DEPTH];
  logic [XLEN-1:0]     data_q [DEPTH];

  logic head_valid;
  logic head_killed;
  logic push;
  logic pop;
  logic drop;

  assign head_valid  = (count_q != '0);
  assign head_killed = killed_q[rd_ptr_q];

  assign out_valid_o = head_valid & ~head_killed;
  assign out_id_o    = id_q[rd_ptr_q];
  assign out_rd_o    = rd_q[rd_ptr_q];
  assign out_we_o    = we_q[rd_ptr_q];
  assign out_data_o  = data_q[rd_ptr_q];

  // Flush wins over every other operation in the same cycle.
  assign in_ready_o  = ~flush_i & ((count_q < FullCnt) | (out_valid_o & out_ready_i));
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;
  assign drop        = head_valid & head_killed & ~flush_i;

  assign count_o     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop || drop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !(pop || drop)) begin
        count_d = count_q + 1'b1;
      end else if (!push && (pop || drop)) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Stale flags in free slots are harmless: a push always rewrites its slot's flag.
  always_comb begin
    killed_d = killed_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_valid_i && (id_q[i] == kill_id_i) &&
          !(pop && (rd_ptr_q == PtrW'(i)))) begin
        killed_d[i] = 1'b1;
      end
      if (push && (wr_ptr_q == PtrW'(i))) begin
        killed_d[i] = kill_valid_i && (in_id_i == kill_id_i);
      end
    end
    if (flush_i) begin
      killed_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      killed_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      killed_q <= killed_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[wr_ptr_q]   <= in_id_i;
      rd_q[wr_ptr_q]   <= in_rd_i;
      we_q[wr_ptr_q]   <= in_we_i;
      data_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_fpu_ss_result_fifo.sv
// Bench for fpu_ss_result_fifo: directed vector table, reset sequence and a
// randomized run against a queue-based reference model.
module tb_fpu_ss_result_fifo;

  localparam int DEPTH = 4;
  localparam int IDW   = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [IDW-1:0]  in_id;
  logic [4:0]      in_rd;
  logic            in_we;
  logic [XLEN-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [IDW-1:0]  out_id;
  logic [4:0]      out_rd;
  logic            out_we;
  logic [XLEN-1:0] out_data;
  logic            kill_valid;
  logic [IDW-1:0]  kill_id;
  logic            flush;
  logic [CW-1:0]   count;

  fpu_ss_result_fifo #(
    .DEPTH    (DEPTH),
    .ID_WIDTH (IDW),
    .XLEN     (XLEN)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_id_i      (in_id),
    .in_rd_i      (in_rd),
    .in_we_i      (in_we),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_id_o     (out_id),
    .out_rd_o     (out_rd),
    .out_we_o     (out_we),
    .out_data_o   (out_data),
    .kill_valid_i (kill_valid),
    .kill_id_i    (kill_id),
    .flush_i      (flush),
    .count_o      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic           iv;
    logic [IDW-1:0] id;
    logic           ordy;
    logic           kv;
    logic [IDW-1:0] kid;
    logic           fl;
    logic [CW-1:0]  ecnt;
    logic           eov;
    logic           eir;
    logic [IDW-1:0] eoid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input int id, input logic ordy, input logic kv,
                     input int kid, input logic fl, input int ecnt, input logic eov,
                     input logic eir, input int eoid);
    vec_t v;
    v.iv = iv; v.id = IDW'(id); v.ordy = ordy; v.kv = kv; v.kid = IDW'(kid); v.fl = fl;
    v.ecnt = CW'(ecnt); v.eov = eov; v.eir = eir; v.eoid = IDW'(eoid);
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_id = '0; in_rd = '0; in_we = 0; in_data = '0;
    out_ready = 0; kill_valid = 0; kill_id = '0; flush = 0;
  endtask

  typedef struct {
    logic [IDW-1:0]  id;
    logic [4:0]      rd;
    logic            we;
    logic [XLEN-1:0] data;
    bit              killed;
  } ent_t;

  ent_t mq[$];

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset count", 64'(count), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // iv id or kv kid fl | cnt ov ir oid
    // In-order drain of a full FIFO; push into full with no pop is refused.
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 2, 0, 0, 0, 0, 1, 1, 1, 1);
    add(1, 3, 0, 0, 0, 0, 2, 1, 1, 1);
    add(1, 4, 0, 0, 0, 0, 3, 1, 1, 1);
    add(1, 6, 0, 0, 0, 0, 4, 1, 0, 1);
    add(0, 0, 1, 0, 0, 0, 4, 1, 1, 1);
    add(0, 0, 1, 0, 0, 0, 3, 1, 1, 2);
    add(0, 0, 1, 0, 0, 0, 2, 1, 1, 3);
    add(0, 0, 1, 0, 0, 0, 1, 1, 1, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // Push into full with simultaneous pop.
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 2, 0, 0, 0, 0, 1, 1, 1, 1);
    add(1, 3, 0, 0, 0, 0, 2, 1, 1, 1);
    add(1, 4, 0, 0, 0, 0, 3, 1, 1, 1);
    add(1, 5, 1, 0, 0, 0, 4, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 4, 1, 0, 2);
    add(0, 0, 1, 0, 0, 0, 4, 1, 1, 2);
    add(0, 0, 1, 0, 0, 0, 3, 1, 1, 3);
    add(0, 0, 1, 0, 0, 0, 2, 1, 1, 4);
    add(0, 0, 1, 0, 0, 0, 1, 1, 1, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // Kill a stored middle entry.
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 2, 0, 0, 0, 0, 1, 1, 1, 1);
    add(1, 3, 0, 0, 0, 0, 2, 1, 1, 1);
    add(0, 0, 0, 1, 2, 0, 3, 1, 1, 1);
    add(0, 0, 1, 0, 0, 0, 3, 1, 1, 1);
    add(0, 0, 1, 0, 0, 0, 2, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 1, 1, 3);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    // Kill aimed at the head while it pops does not disturb the pop.
    add(1, 9, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 1, 9, 0, 1, 1, 1, 9);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // Kill in the same cycle as the push.
    add(1, 7, 0, 1, 7, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // Flush with concurrent push.
    add(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 2, 0, 0, 0, 0, 1, 1, 1, 1);
    add(1, 3, 0, 0, 0, 0, 2, 1, 1, 1);
    add(1, 4, 0, 0, 0, 1, 3, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);

    foreach (tbl[r]) begin
      in_valid = tbl[r].iv; in_id = tbl[r].id; in_rd = {1'b0, tbl[r].id};
      in_we = tbl[r].id[0]; in_data = 32'hD000_0000 | 32'(tbl[r].id);
      out_ready = tbl[r].ordy; kill_valid = tbl[r].kv; kill_id = tbl[r].kid;
      flush = tbl[r].fl;
      @(negedge clk);
      chk($sformatf("row%0d count", r), 64'(count), 64'(tbl[r].ecnt));
      chk($sformatf("row%0d out_valid", r), 64'(out_valid), 64'(tbl[r].eov));
      chk($sformatf("row%0d in_ready", r), 64'(in_ready), 64'(tbl[r].eir));
      if (tbl[r].eov) begin
        chk($sformatf("row%0d out_id", r), 64'(out_id), 64'(tbl[r].eoid));
        chk($sformatf("row%0d out_data", r), 64'(out_data),
            64'(32'hD000_0000 | 32'(tbl[r].eoid)));
      end
      @(posedge clk); #1;
    end

    // Reset asserted mid-operation with two entries stored.
    idle_inputs();
    in_valid = 1; in_id = 4'd1;
    @(posedge clk); #1;
    in_id = 4'd2;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("pre-reset count", 64'(count), 64'd2);
    @(posedge clk); #1;
    rst_n = 0;
    @(negedge clk);
    chk("in-reset count", 64'(count), 64'd0);
    chk("in-reset out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("post-reset count", 64'(count), 64'd0);
    chk("post-reset out_valid", 64'(out_valid), 64'd0);
    chk("post-reset in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Randomized run against the reference queue.
    mq.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bit   exp_ov, exp_ir, do_push, do_pop;
      ent_t e;
      in_valid   = ($urandom_range(0, 9) < 6);
      in_id      = IDW'($urandom_range(0, 7));
      in_rd      = 5'($urandom);
      in_we      = 1'($urandom);
      in_data    = $urandom;
      out_ready  = ($urandom_range(0, 9) < 6);
      kill_valid = ($urandom_range(0, 9) == 0);
      kill_id    = IDW'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 49) == 0);

      exp_ov  = (mq.size() > 0) && !mq[0].killed;
      exp_ir  = !flush && ((mq.size() < DEPTH) || (exp_ov && out_ready));
      do_push = in_valid && exp_ir;
      do_pop  = exp_ov && out_ready && !flush;

      @(negedge clk);
      chk("rand count", 64'(count), 64'(mq.size()));
      chk("rand out_valid", 64'(out_valid), 64'(exp_ov));
      chk("rand in_ready", 64'(in_ready), 64'(exp_ir));
      if (exp_ov) begin
        chk("rand out_id", 64'(out_id), 64'(mq[0].id));
        chk("rand out_rd", 64'(out_rd), 64'(mq[0].rd));
        chk("rand out_we", 64'(out_we), 64'(mq[0].we));
        chk("rand out_data", 64'(out_data), 64'(mq[0].data));
      end

      if (flush) begin
        mq.delete();
      end else begin
        // A head leaves either by handshake or because it was killed earlier.
        if (do_pop || (mq.size() > 0 && mq[0].killed)) void'(mq.pop_front());
        if (kill_valid) begin
          foreach (mq[i]) if (mq[i].id == kill_id) mq[i].killed = 1;
        end
        if (do_push) begin
          e.id = in_id; e.rd = in_rd; e.we = in_we; e.data = in_data;
          e.killed = kill_valid && (kill_id == in_id);
          mq.push_back(e);
        end
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
